// File: rtl/stats_pkg.sv
// Shared types and constants for the packet statistics block: receive FSM
// states, display-select encoding and a small width helper.
package stats_pkg;

    typedef enum logic [1:0] {
        ST_DRAIN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RX    = 2'd2
    } state_t;

    localparam logic [1:0] SEL_FRAMES = 2'd0;
    localparam logic [1:0] SEL_GOOD   = 2'd1;
    localparam logic [1:0] SEL_BAD    = 2'd2;
    localparam logic [1:0] SEL_LEN    = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_counter.sv
// Rising-edge detector feeding a CNT_W event counter; the counter either
// saturates or wraps, and a synchronous clear overrides any increment.
module edge_counter #(
    parameter int CNT_W    = 14,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sig,
    input  logic             qual,
    output logic [CNT_W-1:0] count
);

    logic sig_d;
    logic rise;

    assign rise = sig & ~sig_d & qual;

    // one-cycle delayed copy of the monitored level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end

    // event counter with clear priority and overflow policy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (rise) begin
            if ((SATURATE != 0) && (count == {CNT_W{1'b1}})) begin
                count <= count;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/packet_stats.sv
// Frame / checksum statistics: counts received frames, good and bad checksums,
// latches the last frame length in bytes and presents one statistic at a time.
module packet_stats
    import stats_pkg::*;
#(
    parameter int CNT_W    = 14,
    parameter int LEN_W    = 16,
    parameter int SATURATE = 1,
    localparam int OUT_W   = max_int(CNT_W, LEN_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axiiv,
    input  logic             done,
    input  logic             kill,
    input  logic             clr,
    input  logic [1:0]       sel,
    output logic [OUT_W-1:0] count_out,
    output logic             frame_active,
    output logic             done_flag,
    output logic             kill_flag
);

    localparam int DIB_W = LEN_W + 2;

    state_t           state;
    logic [DIB_W-1:0] dibit_cnt;
    logic [LEN_W-1:0] last_len;
    logic             frame_start;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] bad_cnt;

    assign frame_start = (state == ST_IDLE) && axiiv;

    // receive FSM with dibit counter and byte-length capture; DRAIN swallows
    // any frame already in flight when reset is released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_DRAIN;
            dibit_cnt <= '0;
            last_len  <= '0;
        end else begin
            case (state)
                ST_DRAIN: begin
                    if (!axiiv) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_DRAIN;
                    end
                end
                ST_IDLE: begin
                    if (axiiv) begin
                        state     <= ST_RX;
                        dibit_cnt <= DIB_W'(1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RX: begin
                    if (axiiv) begin
                        if (dibit_cnt != {DIB_W{1'b1}}) begin
                            dibit_cnt <= dibit_cnt + DIB_W'(1);
                        end else begin
                            dibit_cnt <= dibit_cnt;
                        end
                    end else begin
                        state    <= ST_IDLE;
                        last_len <= dibit_cnt[DIB_W-1:2];
                    end
                end
                default: begin
                    state <= ST_DRAIN;
                end
            endcase
            if (clr) begin
                last_len <= '0;
            end
        end
    end

    edge_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_frames (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .sig   (frame_start),
        .qual  (1'b1),
        .count (frame_cnt)
    );

    // a simultaneous kill turns a done edge into a bad-only event
    edge_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_good (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .sig   (done),
        .qual  (~kill),
        .count (good_cnt)
    );

    edge_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_bad (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .sig   (kill),
        .qual  (1'b1),
        .count (bad_cnt)
    );

    // registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_active <= 1'b0;
            done_flag    <= 1'b0;
            kill_flag    <= 1'b0;
        end else begin
            frame_active <= (state == ST_RX);
            done_flag    <= done;
            kill_flag    <= kill;
        end
    end

    // registered display mux, zero-extended to the common output width
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out <= '0;
        end else begin
            case (sel)
                SEL_FRAMES: count_out <= OUT_W'(frame_cnt);
                SEL_GOOD:   count_out <= OUT_W'(good_cnt);
                SEL_BAD:    count_out <= OUT_W'(bad_cnt);
                SEL_LEN:    count_out <= OUT_W'(last_len);
                default:    count_out <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_stats.sv
// Randomised + directed bench for packet_stats; three instances (default,
// 4-bit saturating, 4-bit wrapping) share one stimulus stream.
module tb_packet_stats;

    logic        clk = 1'b0;
    logic        rst;
    logic        axiiv;
    logic        done;
    logic        kill;
    logic        clr;
    logic [1:0]  sel;
    logic [15:0] out_m, out_s, out_w;
    logic        fa_m, df_m, kf_m;
    logic        fa_s, df_s, kf_s;
    logic        fa_w, df_w, kf_w;

    int compared   = 0;
    int mismatched = 0;

    // reference model: raw event totals since the last clear/reset
    int m_frames, m_good, m_bad, m_len;
    bit p_done, p_kill;

    always #5 clk = ~clk;

    packet_stats #(.CNT_W(14), .LEN_W(16), .SATURATE(1)) dut_m (
        .clk(clk), .rst(rst), .axiiv(axiiv), .done(done), .kill(kill), .clr(clr),
        .sel(sel), .count_out(out_m), .frame_active(fa_m), .done_flag(df_m), .kill_flag(kf_m));

    packet_stats #(.CNT_W(4), .LEN_W(16), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .axiiv(axiiv), .done(done), .kill(kill), .clr(clr),
        .sel(sel), .count_out(out_s), .frame_active(fa_s), .done_flag(df_s), .kill_flag(kf_s));

    packet_stats #(.CNT_W(4), .LEN_W(16), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .axiiv(axiiv), .done(done), .kill(kill), .clr(clr),
        .sel(sel), .count_out(out_w), .frame_active(fa_w), .done_flag(df_w), .kill_flag(kf_w));

    function automatic int expect_cnt(input int n, input int w, input bit sat);
        int top;
        top = (1 << w) - 1;
        if (sat) return (n > top) ? top : n;
        return n % (1 << w);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit a, input bit d, input bit k, input bit c);
        @(negedge clk);
        axiiv = a; done = d; kill = k; clr = c;
        if (c) begin
            m_frames = 0; m_good = 0; m_bad = 0; m_len = 0;
        end else begin
            if (d && !p_done && !k) m_good++;
            if (k && !p_kill) m_bad++;
        end
        p_done = d;
        p_kill = k;
    endtask

    task automatic send_frame(input int n, input bit noisy);
        m_frames++;
        for (int i = 0; i < n; i++) begin
            if (noisy) cycle(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
            else       cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        m_len = n / 4;
        repeat ($urandom_range(2)) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic int exp_sel(input int s, input int w, input bit sat);
        case (s)
            0:       return expect_cnt(m_frames, w, sat);
            1:       return expect_cnt(m_good, w, sat);
            2:       return expect_cnt(m_bad, w, sat);
            default: return m_len;
        endcase
    endfunction

    // sweep all four selects on all three instances, one cycle of latency
    task automatic read_all(input string tag);
        @(negedge clk);
        clr = 1'b0;
        sel = 2'd0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            check($sformatf("%s/sel%0d/w14", tag, s), {16'd0, out_m}, exp_sel(s, 14, 1'b1));
            check($sformatf("%s/sel%0d/sat4", tag, s), {16'd0, out_s}, exp_sel(s, 4, 1'b1));
            check($sformatf("%s/sel%0d/wrap4", tag, s), {16'd0, out_w}, exp_sel(s, 4, 1'b0));
            if (s < 3) sel = 2'(s + 1);
        end
    endtask

    task automatic do_reset(input bit a);
        @(negedge clk);
        rst = 1'b1; axiiv = a; done = 1'b0; kill = 1'b0; clr = 1'b0;
        m_frames = 0; m_good = 0; m_bad = 0; m_len = 0;
        p_done = 1'b0; p_kill = 1'b0;
        #1;
        check("rst/count_out", {16'd0, out_m}, 32'd0);
        check("rst/flags", {29'd0, fa_m, df_m, kf_m}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; axiiv = 1'b0; done = 1'b0; kill = 1'b0; clr = 1'b0; sel = 2'd0;
        do_reset(1'b0);
        read_all("reset");

        // three 8-dibit frames
        repeat (3) send_frame(8, 1'b0);
        read_all("three_frames");

        // frame_active timing inside and after a frame
        m_frames++;
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("frame_active_mid", {31'd0, fa_m}, 32'd1);
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        m_len = 2;
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("frame_active_idle", {31'd0, fa_m}, 32'd0);

        // five good checksums then a simultaneous done+kill
        repeat (5) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("done_flag", {31'd0, df_m}, 32'd1);
        check("kill_flag", {31'd0, kf_m}, 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        read_all("good5_bad1");

        // clear racing a done edge with good=7
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (7) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        read_all("good7");
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        read_all("clr_vs_done");

        // 20 frames: 4-bit instances saturate at 15 / wrap to 4
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) send_frame(4 + $urandom_range(3), 1'b0);
        read_all("twenty_frames");

        // randomised traffic
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(3))
                0, 1: send_frame(1 + $urandom_range(39), 1'b1);
                2: begin
                    repeat (1 + $urandom_range(5))
                        cycle(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
                    cycle(1'b0, 1'b0, 1'b0, 1'b0);
                end
                default: begin
                    if ($urandom_range(3) == 0) cycle(1'b0, 1'b0, 1'b0, 1'b1);
                    cycle(1'b0, 1'b0, 1'b0, 1'b0);
                end
            endcase
            if ((it % 8) == 7) read_all($sformatf("rand%0d", it));
        end

        // frame in progress across reset release is drained
        do_reset(1'b1);
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(40, 1'b0);
        read_all("drain_then_40");

        // reset mid-frame after 12 dibits, axiiv still high
        m_frames++;
        repeat (12) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset(1'b1);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        read_all("mid_rst_held");
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8, 1'b0);
        read_all("mid_rst_resume");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/packet_stats.md
PACKET_STATS -- requirements
Module: packet_stats

Interface
REQ-001 Parameter CNT_W, default 14: width of each event counter.
REQ-002 Parameter LEN_W, default 16: width of the frame-length (byte) register.
REQ-003 Parameter SATURATE, default 1: 1 = counters hold at max; 0 = counters wrap to 0.
REQ-004 Port clk  input  1  sole clock (ethernet reference clock domain).
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port axiiv  input  1  receive-data valid from the PHY front end, high for the whole frame.
REQ-007 Port done  input  1  checksum-complete indication.
REQ-008 Port kill  input  1  checksum-failure indication.
REQ-009 Port clr  input  1  synchronous clear of all counters and the length register.
REQ-010 Port sel  input  2  display select: 0 = frames, 1 = good, 2 = bad, 3 = last length.
REQ-011 Port count_out  output  max(CNT_W,LEN_W)  selected statistic, zero-extended.
REQ-012 Port frame_active  output  1  high while state = RX.
REQ-013 Port done_flag, kill_flag  output  1 each  registered copies of done and kill.

Function
REQ-014 FSM states: DRAIN, IDLE, RX.
- DRAIN->IDLE when axiiv=0.
- IDLE->RX when axiiv=1.
- RX->IDLE when axiiv=0.
REQ-015 On the IDLE->RX transition, frame_cnt increments and the dibit counter loads 1.
REQ-016 In RX with axiiv=1, the dibit counter increments (width LEN_W+2), saturating at all-ones regardless of SATURATE.
REQ-017 On the RX->IDLE transition, last_len loads dibit counter >> 2 (floor of bytes); trailing 1-3 dibits are dropped.
REQ-018 A frame in progress at reset release (axiiv=1) is not counted and its length is not latched; DRAIN absorbs it.
REQ-019 good_cnt increments on a rising edge of done when kill=0 in the same cycle.
REQ-020 bad_cnt increments on a rising edge of kill; simultaneous done and kill rising edges count as bad only.
REQ-021 Rising-edge detection compares against a one-cycle-delayed copy; a level held high counts once.
REQ-022 Counter overflow:
- SATURATE=1: a counter at 2^CNT_W-1 stays there.
- SATURATE=0: the counter wraps to 0.
REQ-023 clr=1 zeroes frame_cnt, good_cnt, bad_cnt and last_len.
- clr overrides any increment or load in the same cycle.
- clr does not change FSM state or the dibit counter.
REQ-024 count_out is registered: it reflects sel and the counter values from the previous cycle (latency 1).
REQ-025 frame_active, done_flag and kill_flag are registered, with 1-cycle latency from their sources.

Reset
REQ-026 rst=1 asynchronously sets:
- state = DRAIN;
- all counters, last_len, the dibit counter and count_out = 0;
- edge-delay registers, frame_active, done_flag and kill_flag = 0.
REQ-027 Reset asserted mid-frame discards the partial frame; counting resumes only after axiiv has been observed low.

Structure
REQ-028 Shared package stats_pkg holds:
- the FSM state enum;
- the sel encoding constants (SEL_FRAMES, SEL_GOOD, SEL_BAD, SEL_LEN).
REQ-029 Sub-module edge_counter implements one rising-edge detector plus a CNT_W counter with SATURATE and clr.
- It is instantiated three times: frames, good, bad.
- The frame instance is driven by the FSM IDLE->RX strobe.

Verification
REQ-030 Reset release with axiiv=0, then 3 frames of 8 dibits each -> frame_cnt=3, last_len=2, sel=0 gives count_out=3 one cycle later.
REQ-031 axiiv high across reset release for 10 cycles, then one 40-dibit frame -> frame_cnt=1, last_len=10.
REQ-032 done pulses 5 times with kill=0, then done and kill rise together once -> good_cnt=5, bad_cnt=1.
REQ-033 CNT_W=4, SATURATE=1, 20 frames -> frame_cnt=15; with SATURATE=0, 20 frames -> frame_cnt=4.
REQ-034 clr asserted in the same cycle as a done rising edge, with good_cnt=7 -> good_cnt=0 on the next cycle.
REQ-035 rst pulsed mid-frame after 12 dibits with axiiv still high -> all counts 0, and no frame is counted until axiiv falls and rises again.
